pc_fetch_controller: RTL



---
 rtl/pc_fetch_controller_pkg.sv | 14 +
 rtl/pc_fetch_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_controller_pkg.sv
// Shared types and constants for the fetch-side PC controller.
package pc_fetch_controller_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   localparam int          INSTR_BYTES          = 4;
   localparam logic [31:0] DEF_RESET_VECTOR     = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_controller.sv
// Fetch controller: drives the external PC register, issues req/ack instruction
// fetches and keeps a one-entry IF/ID buffer that honours decode stalls and branch flushes.
module pc_fetch_controller
   import pc_fetch_controller_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                INSTR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [ADDR_W-1:0]  PCResult,
   output logic [ADDR_W-1:0]  Address,
   output logic               PC_en,
   output logic               IMemReq,
   output logic [ADDR_W-1:0]  IMemAddr,
   input  logic               IMemAck,
   input  logic [INSTR_W-1:0] IMemRdata,
   input  logic               Stall,
   input  logic               BranchTaken,
   input  logic [ADDR_W-1:0]  BranchTarget,
   output logic [INSTR_W-1:0] Instr,
   output logic [ADDR_W-1:0]  InstrPC,
   output logic               InstrValid
);

   fetch_state_t      state_q, state_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
   logic              pcen_q;
   logic              pc_en_c, req_c, load_instr, clr_valid;
   logic [ADDR_W-1:0] addr_c;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] seq_pc;

   assign br_tgt = BranchTarget & ~ADDR_W'(3);
   assign seq_pc = PCResult + ADDR_W'(INSTR_BYTES);

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      pc_en_c    = 1'b0;
      addr_c     = PCResult;
      req_c      = 1'b0;
      load_instr = 1'b0;
      clr_valid  = 1'b0;
      case (state_q)
         BOOT: begin
            pc_en_c = 1'b1;
            addr_c  = RESET_VECTOR;
            state_d = FETCH;
         end
         FETCH: begin
            if (BranchTaken || pend_q) begin
               clr_valid = 1'b1;
               // A redirect right after a PC load is deferred one cycle so PC_en never pulses back to back
               if (pcen_q) begin
                  pend_d = 1'b1;
                  if (BranchTaken) pend_tgt_d = br_tgt;
               end else begin
                  pc_en_c = 1'b1;
                  addr_c  = BranchTaken ? br_tgt : pend_tgt_q;
                  pend_d  = 1'b0;
               end
            end else if (InstrValid && Stall) begin
               state_d = HOLD;
            end else begin
               req_c     = 1'b1;
               clr_valid = 1'b1;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            req_c = 1'b1;
            if (IMemAck) begin
               pc_en_c = 1'b1;
               pend_d  = 1'b0;
               state_d = FETCH;
               if (BranchTaken) begin
                  addr_c    = br_tgt;
                  clr_valid = 1'b1;
               end else if (pend_q) begin
                  addr_c    = pend_tgt_q;
                  clr_valid = 1'b1;
               end else begin
                  addr_c     = seq_pc;
                  load_instr = 1'b1;
               end
            end else if (BranchTaken) begin
               pend_d     = 1'b1;
               pend_tgt_d = br_tgt;
            end
         end
         HOLD: begin
            if (BranchTaken) begin
               pc_en_c   = 1'b1;
               addr_c    = br_tgt;
               clr_valid = 1'b1;
               state_d   = FETCH;
            end else if (!Stall) begin
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // Strobes are gated by Reset so they drop the instant reset asserts
   assign PC_en    = pc_en_c && !Reset;
   assign IMemReq  = req_c && !Reset;
   assign Address  = addr_c;
   assign IMemAddr = PCResult;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= BOOT;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
         pcen_q     <= 1'b0;
         Instr      <= '0;
         InstrPC    <= '0;
         InstrValid <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
         pcen_q     <= pc_en_c;
         if (load_instr) begin
            Instr      <= IMemRdata;
            InstrPC    <= PCResult;
            InstrValid <= 1'b1;
         end else if (clr_valid) begin
            InstrValid <= 1'b0;
         end
      end
   end

endmodule
